// File: rtl/reg_pc_stack.sv
// rtl/reg_pc_stack.sv - fetch-stage program counter with step, relative branch and return-address stack
module reg_pc_stack #(
   parameter int WIDTH       = 16,
   parameter int DEPTH       = 4,
   parameter int RESET_VALUE = 0,
   parameter int STEP        = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall,
   input  logic                         inc,
   input  logic                         load_enable,
   input  logic                         rel_enable,
   input  logic                         call,
   input  logic                         ret,
   input  logic                         clear_err,
   input  logic [WIDTH-1:0]             data_in,
   input  logic [WIDTH-1:0]             offset,
   output logic [WIDTH-1:0]             data_out,
   output logic [$clog2(DEPTH+1)-1:0]   stack_depth,
   output logic                         stack_full,
   output logic                         stack_empty,
   output logic                         overflow_err,
   output logic                         underflow_err
);

   // Depth counter must represent 0..DEPTH inclusive; the array index only 0..DEPTH-1.
   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);
   localparam logic [DW-1:0]    DEPTH_W = DW'(DEPTH);
   localparam logic [DW-1:0]    ONE_D   = DW'(1);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;
   logic [DW-1:0]    depth_q;
   logic [DW-1:0]    depth_d;
   logic             ovf_q;
   logic             ovf_d;
   logic             udf_q;
   logic             udf_d;

   logic             push_en;
   logic [WIDTH-1:0] push_data;
   logic [AW-1:0]    push_idx;
   logic [AW-1:0]    pop_idx;
   logic             full;
   logic             empty;

   // Array is rounded up to a power of two so the index width matches exactly;
   // entries at or above DEPTH are never written or read.
   logic [WIDTH-1:0] stack_mem [2**AW];

   assign full     = (depth_q == DEPTH_W);
   assign empty    = (depth_q == '0);
   // Push only happens when not full, so depth_q < DEPTH fits in AW bits.
   assign push_idx = depth_q[AW-1:0];
   // Pop only happens when not empty, so depth_q - 1 is a valid entry.
   assign pop_idx  = AW'(depth_q - ONE_D);

   // Next-state decode: stall freezes everything, otherwise one command by priority.
   always_comb begin
      pc_d      = pc_q;
      depth_d   = depth_q;
      ovf_d     = ovf_q;
      udf_d     = udf_q;
      push_en   = 1'b0;
      push_data = pc_q + STEP_W;

      if (!stall) begin
         // Clearing first lets a flag set later in this block win over the clear.
         if (clear_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
         end

         if (ret) begin
            if (!empty) begin
               pc_d    = stack_mem[pop_idx];
               depth_d = depth_q - ONE_D;
            end else begin
               udf_d = 1'b1;
            end
         end else if (call) begin
            if (!full) begin
               push_en = 1'b1;
               pc_d    = data_in;
               depth_d = depth_q + ONE_D;
            end else begin
               ovf_d = 1'b1;
            end
         end else if (load_enable) begin
            pc_d = data_in;
         end else if (rel_enable) begin
            // offset is already WIDTH bits; modular add gives two's-complement branch.
            pc_d = pc_q + offset;
         end else if (inc) begin
            pc_d = pc_q + STEP_W;
         end
      end
   end

   // PC, depth and sticky flags; asynchronous reset abandons any in-flight command.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_W;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Return-address storage; contents need no reset because depth gates every read.
   always_ff @(posedge clk) begin
      if (push_en && !reset) begin
         stack_mem[push_idx] <= push_data;
      end
   end

   assign data_out      = pc_q;
   assign stack_depth   = depth_q;
   assign stack_full    = full;
   assign stack_empty   = empty;
   assign overflow_err  = ovf_q;
   assign underflow_err = udf_q;

endmodule
